// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
// Entry layout is the prefetch FIFO word: instruction plus its PC.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction memory request/response bus and decode-side handshake.
// master = fetch unit, slave = memory plus decode.
interface inst_fetch_unit_if #(
  parameter int XLEN = 32
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_valid;
  logic            inst_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output inst, inst_pc, inst_valid,
    input  inst_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  inst, inst_pc, inst_valid,
    output inst_ready
  );

endinterface

// File: rtl/inst_fetch_unit_sync_fifo.sv
// Power-of-two synchronous FIFO with flush; registered storage,
// head word read straight from the array (no bypass).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign do_pop = pop & ~empty;
  assign dout   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      if (do_pop)
        rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wptr] <= din;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// PC generation, credit-limited imem issue, in-order response capture
// with drop counting after redirects, and the decode-side prefetch FIFO.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4,
  parameter logic [31:0]     NOP_INST = fetch_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_en,
  input  logic            PCSel,
  input  logic [XLEN-1:0] pc_target,
  inst_fetch_unit_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   out_dec;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] pcq [DEPTH];
  logic [AW-1:0]   pcq_w;
  logic [AW-1:0]   pcq_r;
  logic            redirect;
  logic            credit_ok;
  logic            accept;
  logic            dropping;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  fetch_entry_t    push_e;
  fetch_entry_t    head_e;

  assign redirect  = PCSel & clk_en;
  assign credit_ok = ({1'b0, count} + {1'b0, outstanding})
                   < (CW+1)'(DEPTH);
  assign accept    = bus.imem_req & bus.imem_gnt;
  assign dropping  = bus.imem_rvalid & (drop_cnt != '0);
  assign push      = bus.imem_rvalid & ~dropping & ~redirect;
  assign pop       = bus.inst_valid & bus.inst_ready & clk_en;
  assign out_dec   = outstanding - CW'(bus.imem_rvalid);

  assign bus.imem_req  = clk_en & ~PCSel & credit_ok;
  assign bus.imem_addr = fetch_pc;

  always_comb begin
    push_e      = '0;
    push_e.inst = bus.imem_rdata[31:0];
    push_e.pc   = pcq[pcq_r];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      pcq_w       <= '0;
      pcq_r       <= '0;
    end else begin
      if (redirect)
        fetch_pc <= {pc_target[XLEN-1:2], 2'b00};
      else if (accept)
        fetch_pc <= fetch_pc + XLEN'(4);
      if (accept)
        pcq_w <= pcq_w + AW'(1);
      if (bus.imem_rvalid)
        pcq_r <= pcq_r + AW'(1);
      outstanding <= out_dec + CW'(accept);
      // everything still in flight after a redirect is stale
      if (redirect)
        drop_cnt <= out_dec;
      else if (dropping)
        drop_cnt <= drop_cnt - CW'(1);
      assert (!(push && fifo_full && !pop));
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      pcq[pcq_w] <= fetch_pc;
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (push_e),
    .dout  (head_e),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.inst_valid = ~fifo_empty;
  assign bus.inst       = fifo_empty ? NOP_INST : head_e.inst;
  assign bus.inst_pc    = fifo_empty ? '0 : head_e.pc;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: 1-cycle in-order memory model
// returning the address as data, checks sampled on the falling edge.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic        PCSel;
  logic [31:0] pc_target;
  logic        hold;
  int          n_cmp;
  int          n_err;
  int          acc_cnt;
  int          pop_cnt;
  logic [31:0] last_pc;
  logic [31:0] pend [$];

  inst_fetch_unit_if #(.XLEN(32)) bus ();

  inst_fetch_unit dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .PCSel     (PCSel),
    .pc_target (pc_target),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
      bus.imem_rvalid <= 1'b0;
      bus.imem_rdata  <= '0;
    end else begin
      if (!hold && pend.size() > 0) begin
        bus.imem_rvalid <= 1'b1;
        bus.imem_rdata  <= pend[0];
        void'(pend.pop_front());
      end else begin
        bus.imem_rvalid <= 1'b0;
        bus.imem_rdata  <= '0;
      end
      if (bus.imem_req && bus.imem_gnt)
        pend.push_back(bus.imem_addr);
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      acc_cnt <= 0;
      pop_cnt <= 0;
    end else begin
      if (bus.imem_req && bus.imem_gnt)
        acc_cnt <= acc_cnt + 1;
      if (bus.inst_valid && bus.inst_ready && clk_en) begin
        pop_cnt <= pop_cnt + 1;
        last_pc <= bus.inst_pc;
      end
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clk_en = 1'b0;
    PCSel = 1'b0;
    pc_target = '0;
    bus.inst_ready = 1'b0;
    hold = 1'b0;
    step(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    last_pc = '0;
    bus.imem_gnt = 1'b1;
    do_reset();
    chk("rst_req", bus.imem_req, 0);
    chk("rst_inst", bus.inst, 32'h13);
    chk("rst_pc", bus.inst_pc, 0);
    chk("rst_valid", bus.inst_valid, 0);

    // streaming, then decode stall and resume
    rst = 0; clk_en = 1; bus.inst_ready = 1; #1;
    chk("a_req0", bus.imem_req, 1);
    chk("a_addr0", bus.imem_addr, 0);
    step(); chk("a_addr1", bus.imem_addr, 4);
    chk("a_v1", bus.inst_valid, 0);
    step(); chk("a_addr2", bus.imem_addr, 8);
    chk("a_v2", bus.inst_valid, 0);
    step(); chk("a_v3", bus.inst_valid, 1);
    chk("a_pc3", bus.inst_pc, 0);
    chk("a_inst3", bus.inst, 0);
    step(); chk("a_pc4", bus.inst_pc, 4);
    step(); chk("a_pc5", bus.inst_pc, 8);
    chk("a_inst5", bus.inst, 8);
    bus.inst_ready = 0;
    step(3); chk("a_stall_req", bus.imem_req, 0);
    chk("a_stall_v", bus.inst_valid, 1);
    chk("a_stall_pc", bus.inst_pc, 8);
    step(2); chk("a_full_req", bus.imem_req, 0);
    chk("a_full_pc", bus.inst_pc, 8);
    chk("a_acc", acc_cnt, 6);
    bus.inst_ready = 1;
    step(); chk("a_pc11", bus.inst_pc, 12);
    chk("a_req11", bus.imem_req, 1);
    chk("a_addr11", bus.imem_addr, 24);
    step(); chk("a_pc12", bus.inst_pc, 16);
    step(); chk("a_pc13", bus.inst_pc, 20);
    step(); chk("a_pc14", bus.inst_pc, 24);
    chk("a_inst14", bus.inst, 24);

    // redirect with same-cycle response and pop
    PCSel = 1; pc_target = 32'h100; #1;
    chk("r_req", bus.imem_req, 0);
    step(); PCSel = 0; #1;
    chk("r_v15", bus.inst_valid, 0);
    chk("r_req15", bus.imem_req, 1);
    chk("r_addr15", bus.imem_addr, 32'h100);
    chk("r_last15", last_pc, 24);
    step(); chk("r_v16", bus.inst_valid, 0);
    chk("r_addr16", bus.imem_addr, 32'h104);
    step(); chk("r_v17", bus.inst_valid, 0);
    step(); chk("r_v18", bus.inst_valid, 1);
    chk("r_pc18", bus.inst_pc, 32'h100);
    chk("r_inst18", bus.inst, 32'h100);
    chk("r_last18", last_pc, 24);

    // redirect with two requests outstanding and a word buffered
    do_reset();
    rst = 0; clk_en = 1;
    step(2); hold = 1;
    step(); chk("b_v3", bus.inst_valid, 1);
    chk("b_pc3", bus.inst_pc, 0);
    PCSel = 1; pc_target = 32'h100; #1;
    chk("b_req3", bus.imem_req, 0);
    step(); PCSel = 0; hold = 0; #1;
    chk("b_v4", bus.inst_valid, 0);
    chk("b_req4", bus.imem_req, 1);
    chk("b_addr4", bus.imem_addr, 32'h100);
    step(); chk("b_v5", bus.inst_valid, 0);
    step(2); chk("b_v7", bus.inst_valid, 0);
    step(); chk("b_v8", bus.inst_valid, 1);
    chk("b_pc8", bus.inst_pc, 32'h100);
    chk("b_inst8", bus.inst, 32'h100);
    chk("b_pops8", pop_cnt, 0);
    bus.inst_ready = 1;
    step(); chk("b_pc9", bus.inst_pc, 32'h104);
    step(); chk("b_pc10", bus.inst_pc, 32'h108);
    chk("b_pops10", pop_cnt, 2);

    // target alignment and PC wrap
    do_reset();
    rst = 0; clk_en = 1; PCSel = 1; pc_target = 32'h103; #1;
    chk("c_req0", bus.imem_req, 0);
    step(); chk("c_align", bus.imem_addr, 32'h100);
    pc_target = 32'hFFFF_FFFC;
    step(); PCSel = 0; #1;
    chk("c_req2", bus.imem_req, 1);
    chk("c_addr2", bus.imem_addr, 32'hFFFF_FFFC);
    step(); chk("c_wrap", bus.imem_addr, 0);
    step(2); chk("c_v5", bus.inst_valid, 1);
    chk("c_pc5", bus.inst_pc, 32'hFFFF_FFFC);
    chk("c_inst5", bus.inst, 32'hFFFF_FFFC);

    // clock-enable freeze with responses pending, then mid-stream reset
    do_reset();
    rst = 0; clk_en = 1; bus.inst_ready = 1;
    step(2); clk_en = 0;
    step(); chk("d_req3", bus.imem_req, 0);
    chk("d_v3", bus.inst_valid, 1);
    chk("d_pc3", bus.inst_pc, 0);
    step(4); chk("d_v7", bus.inst_valid, 1);
    chk("d_pc7", bus.inst_pc, 0);
    chk("d_req7", bus.imem_req, 0);
    chk("d_addr7", bus.imem_addr, 8);
    chk("d_pops7", pop_cnt, 0);
    clk_en = 1; #1;
    chk("d_req7b", bus.imem_req, 1);
    step(); chk("d_pc8", bus.inst_pc, 4);
    chk("d_pops8", pop_cnt, 1);
    rst = 1;
    step(); chk("d_rst_inst", bus.inst, 32'h13);
    chk("d_rst_v", bus.inst_valid, 0);
    chk("d_rst_pc", bus.inst_pc, 0);
    chk("d_rst_addr", bus.imem_addr, 0);
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Producer side of the instruction interface consumed by control_logic: generates PC, requests words from instruction memory, and buffers returned words in a prefetch FIFO.
- Presents inst/inst_pc to decode with a valid/ready handshake.
- Takes PCSel plus the ALU target back from the datapath to redirect fetch, flushing stale words and in-flight responses.

Parameters:
- XLEN, 32, address/data width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- DEPTH, 4, prefetch FIFO entries (power of 2, ≥2)
- NOP_INST, 32'h0000_0013, value driven on inst when FIFO empty (addi x0,x0,0)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- clk_en  in  1  when 0: no issue, no pop, PC and FIFO hold; response capture/drop still active
- PCSel  in  1  redirect request from control logic (1 = taken branch/jump)
- pc_target  in  XLEN  redirect address (ALU result), sampled when PCSel=1
- imem_req  out  1  fetch request valid
- imem_addr  out  XLEN  fetch address (word aligned)
- imem_gnt  in  1  memory accepts request this cycle (req&gnt = accepted)
- imem_rvalid  in  1  response valid; responses return in request order, latency ≥1
- imem_rdata  in  XLEN  response word
- inst  out  32  FIFO head word, NOP_INST when empty
- inst_pc  out  XLEN  PC of head word, 0 when empty
- inst_valid  out  1  FIFO non-empty
- inst_ready  in  1  decode consumes head (pop on valid&ready&clk_en)

Behaviour:
- Reset (rst=1 at posedge): fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0. Outputs after reset: imem_req=0 until first clk_en cycle; inst=NOP_INST, inst_pc=0, inst_valid=0. Reset mid-operation discards everything; later responses to pre-reset requests are the memory's responsibility (memory is reset on the same rst).
- Issue: imem_req = clk_en & ~PCSel & (count + outstanding < DEPTH); imem_addr = fetch_pc. On req&gnt: fetch_pc += 4 (wraps modulo 2^XLEN), outstanding++. Entry PC is recorded in a parallel PC queue at issue time.
- Response: on imem_rvalid with drop_cnt>0 → discard, drop_cnt--, outstanding--. Otherwise → push {rdata, pc}, outstanding--. Space is guaranteed by the issue credit rule, so overflow is impossible; a push into a full FIFO is an assertion failure.
- Pop: inst_valid & inst_ready & clk_en → advance head. Push and pop in the same cycle at count=DEPTH-1 or count=1 are legal; count is unchanged.
- Redirect (PCSel=1 & clk_en, one cycle):
  - fetch_pc ← {pc_target[XLEN-1:2], 2'b00}; FIFO flushed, count=0.
  - drop_cnt ← outstanding after this cycle's response decrement. No request is issued this cycle.
  - A response arriving the same cycle is discarded, not pushed.
  - A pop the same cycle completes, since decode already sampled the word.
  - First new request goes out the next cycle.
  - Back-to-back redirects: each reloads PC and accumulates drops correctly.
- Latency: redirect → imem_req at target = 1 cycle. Response → inst_valid = 1 cycle (registered FIFO, no bypass).
- Counters: outstanding and drop_cnt are clog2(DEPTH)+1 bits; drop_cnt ≤ outstanding always.

Decomposition:
- Shared package fetch_pkg: NOP_INST constant, XLEN default, and a typedef for the FIFO entry {inst, pc}.
- One sub-module: sync_fifo (parameterised width/depth, push/pop/flush, count, full/empty), instantiated once for entries.
- The credit/drop logic and PC register stay in inst_fetch_unit.

Test Plan:
- Reset then clk_en=1, gnt=1, 1-cycle memory returning addr as data, ready=1 → imem_addr 0,4,8…; inst_valid from cycle 3; inst_pc/inst = 0,4,8 in order.
- inst_ready=0 with DEPTH=4 → exactly 4 requests total, imem_req stays 0; raising ready resumes issue; no word lost or duplicated.
- PCSel=1, pc_target=32'h100 while 2 requests are outstanding → both responses dropped; first inst_valid word has inst_pc=32'h100; FIFO contents before redirect never appear.
- Redirect in the same cycle as imem_rvalid and a pop → response discarded, pop completes, drop_cnt=outstanding-1.
- pc_target=32'h103 → imem_addr=32'h100. fetch_pc=32'hFFFF_FFFC → next address 32'h0000_0000.
- clk_en=0 for 5 cycles with responses pending → responses still captured; no issue, no pop, PC unchanged; rst=1 mid-stream → inst=NOP_INST, inst_valid=0, next imem_addr=RESET_PC.
